vinst_queue: RTL and testbench

//  Instruction queue directly upstream of the vector-instruction controller. Buffers sa_inst_t words from
//  the host/sequencer via a valid/ready push port and presents the head entry as inst/iavail. The

---
 rtl/vinst_queue_pkg.sv | 25 ++
 rtl/vinst_queue_mem.sv | 35 +++
 rtl/vinst_queue.sv | 138 +++++++++++++
 tb/tb_vinst_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vinst_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vinst_queue_pkg                                               |
// | Purpose  : Shared types and constants for the vector-instruction queue.  |
// |            sa_inst_t is the instruction word moved between the host and  |
// |            the vector-instruction controller.                            |
// | Config   : none (LAP_IQ_NOP_DROP_EN is consumed by vinst_queue).         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package vinst_queue_pkg;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [7:0]  vsize;
        logic [15:0] addr;
    } sa_inst_t;

    // Default queue depth for the controller front end.
    localparam int LAP_IQ_DEPTH = 8;

    // All-zero opcode is the NOP; an all-zero word is therefore a NOP.
    localparam logic [3:0] LAP_OP_NOP = 4'h0;

endpackage : vinst_queue_pkg
`default_nettype wire

// File: rtl/vinst_queue_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vinst_queue_mem                                               |
// | Purpose  : DEPTH x W storage array, synchronous write, asynchronous read.|
// | Ports    : clk             rising-edge clock                             |
// |            we / waddr / wdata   write port                               |
// |            raddr / rdata        combinational read port                  |
// | Notes    : storage is never reset.                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vinst_queue_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 28,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : vinst_queue_mem
`default_nettype wire

// File: rtl/vinst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vinst_queue                                                   |
// | Purpose  : Show-ahead instruction queue in front of the vector-          |
// |            instruction controller. Host pushes via valid/ready, the      |
// |            controller reads the head on inst/iavail and pops with ird.   |
// | Ports    : clk, reset (sync, active-high)                                |
// |            push_valid, push_inst, push_ready   host push port            |
// |            flush                                discard all entries      |
// |            inst, iavail, ird                    head / pop port          |
// |            count                                occupancy 0..DEPTH       |
// |            ovf_err, unf_err, err_clr            sticky error flags       |
// | Config   : LAP_IQ_NOP_DROP_EN - accepted NOP pushes are not stored.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vinst_queue
    import vinst_queue_pkg::*;
#(
    parameter int DEPTH = LAP_IQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid,
    input  sa_inst_t      push_inst,
    output logic          push_ready,
    input  logic          flush,
    output sa_inst_t      inst,
    output logic          iavail,
    input  logic          ird,
    output logic [AW:0]   count,
    output logic          ovf_err,
    output logic          unf_err,
    input  logic          err_clr
);

    localparam int           c_W    = $bits(sa_inst_t);
    localparam logic [AW:0]  c_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf_err;
    logic          r_unf_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push_acc;
    logic          w_write;
    logic          w_pop;
    logic          w_is_nop;
    logic [c_W-1:0] w_rdata;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);

    // Handshake completes whenever the queue is not full; flush swallows it.
    assign w_push_acc = push_valid & ~w_full & ~flush;
    assign w_pop      = ird & ~w_empty & ~flush;
    assign w_is_nop   = (push_inst.opcode == LAP_OP_NOP);

`ifdef LAP_IQ_NOP_DROP_EN
    assign w_write = w_push_acc & ~w_is_nop;
`else
    assign w_write = w_push_acc;
    // Opcode inspection only matters when NOP dropping is built in.
    logic w_unused_nop;
    assign w_unused_nop = w_is_nop;
`endif

    vinst_queue_mem #(
        .DEPTH (DEPTH),
        .W     (c_W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_write),
        .waddr (r_wr_ptr),
        .wdata (push_inst),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are AW bits wide so they wrap modulo DEPTH for free.
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle as err_clr wins.
    // A flush cycle never raises a flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            if (push_valid & w_full & ~flush) begin
                r_ovf_err <= 1'b1;
            end else if (err_clr) begin
                r_ovf_err <= 1'b0;
            end
            if (ird & w_empty & ~flush) begin
                r_unf_err <= 1'b1;
            end else if (err_clr) begin
                r_unf_err <= 1'b0;
            end
        end
    end

    assign push_ready = ~w_full;
    assign iavail     = ~w_empty;
    // Storage is not cleared, so mask stale contents to a NOP when empty.
    assign inst       = w_empty ? sa_inst_t'('0) : sa_inst_t'(w_rdata);
    assign count      = r_count;
    assign ovf_err    = r_ovf_err;
    assign unf_err    = r_unf_err;

endmodule : vinst_queue
`default_nettype wire

// File: tb/tb_vinst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vinst_queue                                                |
// | Purpose  : Self-checking bench for vinst_queue. A queue-based reference  |
// |            model tracks expected contents and error flags.               |
// | Config   : honours LAP_IQ_NOP_DROP_EN when defined.                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vinst_queue;
    import vinst_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

`ifdef LAP_IQ_NOP_DROP_EN
    localparam bit c_NOP_DROP = 1'b1;
`else
    localparam bit c_NOP_DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    sa_inst_t    push_inst;
    logic        push_ready;
    logic        flush;
    sa_inst_t    inst;
    logic        iavail;
    logic        ird;
    logic [AW:0] count;
    logic        ovf_err;
    logic        unf_err;
    logic        err_clr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    sa_inst_t m_q[$];
    bit       m_ovf;
    bit       m_unf;

    always #5 clk = ~clk;

    vinst_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_inst  (push_inst),
        .push_ready (push_ready),
        .flush      (flush),
        .inst       (inst),
        .iavail     (iavail),
        .ird        (ird),
        .count      (count),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err),
        .err_clr    (err_clr)
    );

    function automatic sa_inst_t mk(input logic [3:0] op, input logic [7:0] vs, input logic [15:0] ad);
        sa_inst_t t;
        t.opcode = op;
        t.vsize  = vs;
        t.addr   = ad;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model.
    task automatic check_all();
        sa_inst_t exp_inst;
        exp_inst = (m_q.size() > 0) ? m_q[0] : sa_inst_t'('0);
        chk("count",      32'(count),      32'(m_q.size()));
        chk("iavail",     32'(iavail),     32'(m_q.size() > 0));
        chk("push_ready", 32'(push_ready), 32'(m_q.size() < DEPTH));
        chk("inst",       32'(inst),       32'(exp_inst));
        chk("ovf_err",    32'(ovf_err),    32'(m_ovf));
        chk("unf_err",    32'(unf_err),    32'(m_unf));
    endtask

    // Apply one cycle of inputs, advance the model, check after the edge.
    task automatic step(input logic rs, input logic pv, input sa_inst_t pi,
                        input logic ir, input logic fl, input logic ec);
        bit room;
        bit ovf_set;
        bit unf_set;
        reset      = rs;
        push_valid = pv;
        push_inst  = pi;
        ird        = ir;
        flush      = fl;
        err_clr    = ec;
        @(posedge clk);
        room    = (m_q.size() < DEPTH);
        ovf_set = !fl && pv && !room;
        unf_set = !fl && ir && (m_q.size() == 0);
        if (rs) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (fl) begin
                m_q.delete();
            end else begin
                if (ir && m_q.size() > 0) void'(m_q.pop_front());
                if (pv && room && !(c_NOP_DROP && pi.opcode == LAP_OP_NOP))
                    m_q.push_back(pi);
            end
            m_ovf = ovf_set ? 1'b1 : (ec ? 1'b0 : m_ovf);
            m_unf = unf_set ? 1'b1 : (ec ? 1'b0 : m_unf);
        end
        #1;
        check_all();
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, 0, 0);
    endtask

    sa_inst_t ri;

    initial begin
        reset = 1'b1; push_valid = 0; push_inst = '0; ird = 0; flush = 0; err_clr = 0;
        m_ovf = 0; m_unf = 0;

        // Reset state
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_inst",  32'(inst),  32'd0);

        // 1. Three back-to-back pushes
        step(0, 1, mk(4'h1, 8'd4, 16'h0100), 0, 0, 0);
        chk("t1_iavail", 32'(iavail), 32'd1);
        step(0, 1, mk(4'h2, 8'd5, 16'h0200), 0, 0, 0);
        step(0, 1, mk(4'h3, 8'd6, 16'h0300), 0, 0, 0);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_vsize", 32'(inst.vsize), 32'd4);

        // 2. Pops
        step(0, 0, '0, 1, 0, 0);
        chk("t2_vsize", 32'(inst.vsize), 32'd5);
        chk("t2_count", 32'(count), 32'd2);
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        chk("t2_iavail", 32'(iavail), 32'd0);
        chk("t2_inst",   32'(inst),   32'd0);

        // 3. Fill, overflow, clear
        for (int i = 0; i < DEPTH; i++) step(0, 1, mk(4'h5, 8'(i + 16), 16'(i)), 0, 0, 0);
        chk("t3_ready", 32'(push_ready), 32'd0);
        step(0, 1, mk(4'h6, 8'hEE, 16'hDEAD), 0, 0, 0);
        chk("t3_ovf", 32'(ovf_err), 32'd1);
        chk("t3_count", 32'(count), 32'd8);
        // Full plus ird: still no pass-through
        step(0, 1, mk(4'h6, 8'hEF, 16'hBEEF), 1, 0, 1);
        chk("t3_cnt_full_pop", 32'(count), 32'd7);
        step(0, 0, '0, 0, 0, 1);
        chk("t3_clr", 32'(ovf_err), 32'd0);

        // 4. Simultaneous push/pop at count 4, across pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 1, mk(4'h7, 8'(i), 16'h4000), 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, mk(4'h7, 8'(i + 4), 16'h4000), 1, 0, 0);
        chk("t4_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t4_seq", 32'(inst.vsize), 32'(i + 20));
            step(0, 0, '0, 1, 0, 0);
        end

        // 5. Underflow, then flush with concurrent push
        step(0, 0, '0, 1, 0, 0);
        chk("t5_unf", 32'(unf_err), 32'd1);
        chk("t5_count", 32'(count), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 1, mk(4'h8, 8'(i), 16'h5000), 0, 0, 0);
        step(0, 1, mk(4'h8, 8'h55, 16'h5555), 0, 1, 0);
        chk("t5_flush_count", 32'(count), 32'd0);
        chk("t5_flush_ovf",   32'(ovf_err), 32'd0);
        chk("t5_unf_held",    32'(unf_err), 32'd1);
        step(0, 0, '0, 0, 0, 1);

        // 6. NOP handling
        do_reset();
        step(0, 1, mk(LAP_OP_NOP, 8'd9, 16'h0), 0, 0, 0);
        step(0, 1, mk(4'h3, 8'd10, 16'h6000), 0, 0, 0);
`ifdef LAP_IQ_NOP_DROP_EN
        chk("t6_count", 32'(count), 32'd1);
        chk("t6_opcode", 32'(inst.opcode), 32'd3);
`else
        chk("t6_count", 32'(count), 32'd2);
        chk("t6_opcode", 32'(inst.opcode), 32'd0);
`endif

        // Randomized traffic against the model, including mid-run reset
        for (int i = 0; i < 400; i++) begin
            ri = mk(4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 60), ri,
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 5));
        end

        // Reset mid-operation with entries queued
        for (int i = 0; i < 3; i++) step(0, 1, mk(4'h9, 8'(i), 16'h9000), 0, 0, 0);
        do_reset();
        chk("rst_mid_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vinst_queue
`default_nettype wire
